wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_arbiter_if.sv | 39 +++
 rtl/wb_starve_ctl.sv | 62 ++++++
 rtl/wb_arbiter.sv | 71 +++++++
 tb/tb_wb_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back arbiter slice: source codes, arbiter states,
// and a helper that maps the execute-path source field onto a legal code.
package wb_pkg;

    localparam int unsigned RD_W = 5;

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_MEM = 2'b01,
        SRC_PC4 = 2'b10
    } wb_src_t;

    typedef enum logic {
        LD_PRI   = 1'b0,
        EX_FORCE = 1'b1
    } arb_state_t;

    // The execute port cannot carry MEM; anything other than PC4 is treated as ALU.
    function automatic wb_src_t ex_src_decode(input logic [1:0] src);
        return (src == SRC_PC4) ? SRC_PC4 : SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the execute/load requesters and the write-back arbiter,
// including the registered register-file write port.
interface wb_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    import wb_pkg::*;

    logic              ex_valid;
    logic [RD_W-1:0]   ex_rd;
    logic [1:0]        ex_src;
    logic [DATA_W-1:0] ex_alu_res;
    logic [DATA_W-1:0] ex_pc4;
    logic              ex_ready;

    logic              ld_valid;
    logic [RD_W-1:0]   ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;

    logic              ru_wr_en;
    logic [RD_W-1:0]   ru_rd;
    logic [DATA_W-1:0] ru_data_wr;
    logic [1:0]        ru_data_wr_src;

    modport master (
        output ex_valid, ex_rd, ex_src, ex_alu_res, ex_pc4,
        output ld_valid, ld_rd, ld_data,
        input  ex_ready, ld_ready,
        input  ru_wr_en, ru_rd, ru_data_wr, ru_data_wr_src
    );

    modport slave (
        input  ex_valid, ex_rd, ex_src, ex_alu_res, ex_pc4,
        input  ld_valid, ld_rd, ld_data,
        output ex_ready, ld_ready,
        output ru_wr_en, ru_rd, ru_data_wr, ru_data_wr_src
    );

endinterface

// File: rtl/wb_starve_ctl.sv
// Load-priority arbitration with a starve counter: after STARVE_LIMIT load wins
// over a waiting execute request, the next grant is forced to execute.
module wb_starve_ctl
    import wb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ex_valid,
    input  logic ld_valid,
    output logic grant_ex,
    output logic grant_ld
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ex_starved;

    always_comb begin
        grant_ex = 1'b0;
        grant_ld = 1'b0;
        if (rst_n) begin
            if (state == EX_FORCE) begin
                grant_ex = ex_valid;
                grant_ld = ld_valid & ~ex_valid;
            end else begin
                grant_ld = ld_valid;
                grant_ex = ex_valid & ~ld_valid;
            end
        end
    end

    // A waiting execute request that lost this cycle is the only thing that counts.
    assign ex_starved = ex_valid & ~grant_ex;

    always_comb begin
        cnt_nxt = '0;
        if (ex_starved) begin
            cnt_nxt = (cnt == LIMIT) ? LIMIT : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LD_PRI;
            cnt   <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (state == LD_PRI && ex_starved && cnt_nxt == LIMIT) begin
                state <= EX_FORCE;
            end else begin
                state <= LD_PRI;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges execute and load-return requests onto one
// registered register-file write port. Define WB_TRACE_EN to print each write.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    logic              grant_ex;
    logic              grant_ld;
    logic [RD_W-1:0]   sel_rd;
    logic [DATA_W-1:0] sel_data;
    wb_src_t           sel_src;

    wb_starve_ctl #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctl (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_valid (bus.ex_valid),
        .ld_valid (bus.ld_valid),
        .grant_ex (grant_ex),
        .grant_ld (grant_ld)
    );

    assign bus.ex_ready = grant_ex;
    assign bus.ld_ready = grant_ld;

    always_comb begin
        sel_src  = ex_src_decode(bus.ex_src);
        sel_rd   = bus.ex_rd;
        sel_data = (sel_src == SRC_PC4) ? bus.ex_pc4 : bus.ex_alu_res;
        if (grant_ld) begin
            sel_src  = SRC_MEM;
            sel_rd   = bus.ld_rd;
            sel_data = bus.ld_data;
        end
    end

    // x0 writes still move the payload registers; only the enable is suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ru_wr_en       <= 1'b0;
            bus.ru_rd          <= '0;
            bus.ru_data_wr     <= '0;
            bus.ru_data_wr_src <= SRC_ALU;
        end else if (grant_ex | grant_ld) begin
            bus.ru_wr_en       <= (sel_rd != '0);
            bus.ru_rd          <= sel_rd;
            bus.ru_data_wr     <= sel_data;
            bus.ru_data_wr_src <= sel_src;
        end else begin
            bus.ru_wr_en       <= 1'b0;
        end
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n && bus.ru_wr_en) begin
            $display("wb_trace: rd %0d data %0d src %02b",
                     bus.ru_rd, $signed(bus.ru_data_wr), bus.ru_data_wr_src);
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a grant model pushes expected write-backs,
// a monitor pops and compares them against the registered ru_* port.
module tb_wb_arbiter;

    localparam int LIMIT = 2;

    typedef struct {
        logic        wr_en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  src;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DATA_W(32)) bus();

    wb_arbiter #(
        .DATA_W      (32),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t last;
    exp_t mon_e;
    int   streak = 0;
    logic [3:0] ld_log = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic req_ex(input logic [4:0] rd, input logic [1:0] src,
                          input logic [31:0] alu, input logic [31:0] pc4);
        bus.ex_valid   = 1'b1;
        bus.ex_rd      = rd;
        bus.ex_src     = src;
        bus.ex_alu_res = alu;
        bus.ex_pc4     = pc4;
    endtask

    task automatic req_ld(input logic [4:0] rd, input logic [31:0] data);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = rd;
        bus.ld_data  = data;
    endtask

    // Called just after a falling edge with requests already driven.
    task automatic cycle();
        logic ge, gl;
        exp_t e;
        #1;
        if (bus.ex_valid && bus.ld_valid) ge = (streak >= LIMIT);
        else                              ge = bus.ex_valid;
        gl = bus.ld_valid && !ge;
        streak = (bus.ex_valid && !ge) ? streak + 1 : 0;
        check("ex_ready", bus.ex_ready, ge);
        check("ld_ready", bus.ld_ready, gl);
        ld_log = {ld_log[2:0], bus.ld_ready};
        if (ge) begin
            e.wr_en = (bus.ex_rd != 0);
            e.rd    = bus.ex_rd;
            e.src   = (bus.ex_src == 2'b10) ? 2'b10 : 2'b00;
            e.data  = (bus.ex_src == 2'b10) ? bus.ex_pc4 : bus.ex_alu_res;
            q.push_back(e);
        end else if (gl) begin
            e.wr_en = (bus.ld_rd != 0);
            e.rd    = bus.ld_rd;
            e.src   = 2'b01;
            e.data  = bus.ld_data;
            q.push_back(e);
        end
        @(posedge clk);
        #2;
        if (ge) bus.ex_valid = 1'b0;
        if (gl) bus.ld_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && (bus.ex_valid || bus.ld_valid); i++) cycle();
        check("drain_bound", {30'd0, bus.ex_valid, bus.ld_valid}, 32'd0);
    endtask

    // Monitor: one expected entry per transfer, otherwise outputs must idle/hold.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    last  = mon_e;
                    check("ru_wr_en", bus.ru_wr_en, mon_e.wr_en);
                    check("ru_rd", bus.ru_rd, mon_e.rd);
                    check("ru_data_wr", bus.ru_data_wr, mon_e.data);
                    check("ru_data_wr_src", bus.ru_data_wr_src, mon_e.src);
                end else begin
                    check("idle_wr_en", bus.ru_wr_en, 1'b0);
                    check("hold_rd", bus.ru_rd, last.rd);
                    check("hold_data", bus.ru_data_wr, last.data);
                    check("hold_src", bus.ru_data_wr_src, last.src);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        last = '{1'b0, 5'd0, 32'd0, 2'd0};
        bus.ex_valid = 1'b0; bus.ex_rd = '0; bus.ex_src = '0;
        bus.ex_alu_res = '0; bus.ex_pc4 = '0;
        bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;

        // Reset values and readies held low while requests are pending.
        req_ex(5'd4, 2'b00, 32'h11, 32'h0);
        req_ld(5'd6, 32'h22);
        @(negedge clk);
        check("rst_ex_ready", bus.ex_ready, 1'b0);
        check("rst_ld_ready", bus.ld_ready, 1'b0);
        check("rst_wr_en", bus.ru_wr_en, 1'b0);
        check("rst_rd", bus.ru_rd, 5'd0);
        check("rst_data", bus.ru_data_wr, 32'd0);
        check("rst_src", bus.ru_data_wr_src, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        drain();
        repeat (2) cycle();

        // Lone execute request with ALU source.
        req_ex(5'd5, 2'b00, 32'h1234, 32'h0);
        cycle();
        cycle();

        // Both held high: LD, LD, EX, LD.
        for (int i = 0; i < 4; i++) begin
            if (!bus.ex_valid) req_ex(5'd10 + 5'(i), 2'b00, 32'h100 + i, 32'h0);
            if (!bus.ld_valid) req_ld(5'd20 + 5'(i), 32'h200 + i);
            cycle();
        end
        check("starve_seq", {28'd0, ld_log}, 32'b1101);
        drain();
        cycle();

        // Load to x0: accepted, no write enable, payload still visible.
        req_ld(5'd0, 32'hFFFF_FFFF);
        cycle();
        cycle();

        // Same rd from both sides: load first, then PC+4.
        req_ex(5'd1, 2'b10, 32'hDEAD, 32'h104);
        req_ld(5'd1, 32'd7);
        drain();
        cycle();

        // Signed load value for trace builds.
        req_ld(5'd9, 32'hFFFF_FFFD);
        cycle();
        cycle();

        // Reset asserted mid-stream with both requests pending.
        req_ld(5'd3, 32'hAAAA);
        cycle();
        req_ex(5'd7, 2'b00, 32'h77, 32'h0);
        req_ld(5'd8, 32'h88);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wr_en", bus.ru_wr_en, 1'b0);
        check("arst_ex_ready", bus.ex_ready, 1'b0);
        check("arst_ld_ready", bus.ld_ready, 1'b0);
        check("arst_rd", bus.ru_rd, 5'd0);
        check("arst_data", bus.ru_data_wr, 32'd0);
        q.delete();
        streak = 0;
        last = '{1'b0, 5'd0, 32'd0, 2'd0};
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!bus.ex_valid) req_ex(5'd12, 2'b10, 32'h0, 32'h300 + i);
            if (!bus.ld_valid) req_ld(5'd13, 32'h400 + i);
            cycle();
        end
        check("post_rst_seq", {29'd0, ld_log[2:0]}, 32'b110);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            if (!bus.ex_valid && $urandom_range(0, 99) < 60)
                req_ex(5'($urandom_range(0, 31)), ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00,
                       $urandom, $urandom);
            if (!bus.ld_valid && $urandom_range(0, 99) < 60)
                req_ld(5'($urandom_range(0, 31)), $urandom);
            cycle();
        end
        drain();
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
